// File: rtl/axi_lite_reg_responder.sv
// AXI4-Lite slave that turns each AXI access into a single strobe on a simple local register bus.
// Define REG_TIMEOUT_EN to add an access timeout that answers SLVERR when the register file stays silent.
`timescale 1ns/1ps
module axi_lite_reg_responder #(
    parameter int AXI_ADDR_WIDTH = 12,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                      axi_clk,
    input  logic                      axi_reset_n,
    input  logic [AXI_ADDR_WIDTH-1:0] axi_awaddr,
    input  logic                      axi_awvalid,
    output logic                      axi_awready,
    input  logic [31:0]               axi_wdata,
    input  logic [3:0]                axi_wstrb,
    input  logic                      axi_wvalid,
    output logic                      axi_wready,
    output logic [1:0]                axi_bresp,
    output logic                      axi_bvalid,
    input  logic                      axi_bready,
    input  logic [AXI_ADDR_WIDTH-1:0] axi_araddr,
    input  logic                      axi_arvalid,
    output logic                      axi_arready,
    output logic [31:0]               axi_rdata,
    output logic [1:0]                axi_rresp,
    output logic                      axi_rvalid,
    input  logic                      axi_rready,
    output logic [AXI_ADDR_WIDTH-1:0] reg_addr,
    output logic                      reg_write,
    output logic                      reg_read,
    output logic [31:0]               reg_writedata,
    output logic [3:0]                reg_beN,
    input  logic                      reg_ack,
    input  logic [31:0]               reg_readdata,
    input  logic                      reg_readdatavalid
);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [AXI_ADDR_WIDTH-1:0] WORD_MASK = ~(AXI_ADDR_WIDTH'(3));

    typedef enum logic [2:0] {IDLE, W_ACCESS, W_RESP, R_ACCESS, R_RESP} state_t;
    state_t state;

    logic                      ports_up;
    logic                      aw_held;
    logic                      w_held;
    logic [AXI_ADDR_WIDTH-1:0] awaddr_q;
    logic [31:0]               wdata_q;
    logic [3:0]                wstrb_q;
    logic                      aw_take;
    logic                      w_take;
    logic                      ar_take;
    logic                      write_go;
    logic [AXI_ADDR_WIDTH-1:0] wr_addr;
    logic [31:0]               wr_data;
    logic [3:0]                wr_strb;

    // ports_up keeps every ready low for the first cycle after reset is released.
    assign axi_awready = ports_up && (state == IDLE) && !aw_held;
    assign axi_wready  = ports_up && (state == IDLE) && !w_held;
    // Any write activity, held or arriving, holds off the read channel so a write always wins.
    assign axi_arready = ports_up && (state == IDLE) && !aw_held && !w_held
                         && !axi_awvalid && !axi_wvalid;

    assign aw_take  = axi_awvalid && axi_awready;
    assign w_take   = axi_wvalid && axi_wready;
    assign ar_take  = axi_arvalid && axi_arready;
    assign write_go = (aw_held || aw_take) && (w_held || w_take);
    assign wr_addr  = aw_held ? awaddr_q : axi_awaddr;
    assign wr_data  = w_held ? wdata_q : axi_wdata;
    assign wr_strb  = w_held ? wstrb_q : axi_wstrb;

`ifdef REG_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CNT_W-1:0] wait_cnt;
    logic             timed_out;

    assign timed_out = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // The counter sits at zero in IDLE, so every access phase starts counting from zero.
    always_ff @(posedge axi_clk) begin
        if (!axi_reset_n || state == IDLE) begin
            wait_cnt <= '0;
        end else if (state == W_ACCESS || state == R_ACCESS) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end
`else
    logic timeout_unused;
    assign timeout_unused = (TIMEOUT_CYCLES != 0);
`endif

    always_ff @(posedge axi_clk) begin
        if (!axi_reset_n) begin
            state         <= IDLE;
            ports_up      <= 1'b0;
            aw_held       <= 1'b0;
            w_held        <= 1'b0;
            awaddr_q      <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            axi_bvalid    <= 1'b0;
            axi_bresp     <= RESP_OKAY;
            axi_rvalid    <= 1'b0;
            axi_rresp     <= RESP_OKAY;
            axi_rdata     <= '0;
            reg_addr      <= '0;
            reg_write     <= 1'b0;
            reg_read      <= 1'b0;
            reg_writedata <= '0;
            reg_beN       <= '0;
        end else begin
            ports_up  <= 1'b1;
            reg_write <= 1'b0;
            reg_read  <= 1'b0;
            case (state)
                IDLE: begin
                    if (write_go) begin
                        aw_held       <= 1'b0;
                        w_held        <= 1'b0;
                        reg_addr      <= wr_addr & WORD_MASK;
                        reg_writedata <= wr_data;
                        reg_beN       <= ~wr_strb;
                        reg_write     <= 1'b1;
                        state         <= W_ACCESS;
                    end else begin
                        if (aw_take) begin
                            aw_held  <= 1'b1;
                            awaddr_q <= axi_awaddr;
                        end
                        if (w_take) begin
                            w_held  <= 1'b1;
                            wdata_q <= axi_wdata;
                            wstrb_q <= axi_wstrb;
                        end
                        if (ar_take) begin
                            reg_addr <= axi_araddr & WORD_MASK;
                            reg_read <= 1'b1;
                            state    <= R_ACCESS;
                        end
                    end
                end
                W_ACCESS: begin
                    if (reg_ack) begin
                        axi_bvalid <= 1'b1;
                        axi_bresp  <= RESP_OKAY;
                        state      <= W_RESP;
                    end
`ifdef REG_TIMEOUT_EN
                    else if (timed_out) begin
                        axi_bvalid <= 1'b1;
                        axi_bresp  <= RESP_SLVERR;
                        state      <= W_RESP;
                    end
`endif
                end
                W_RESP: begin
                    if (axi_bready) begin
                        axi_bvalid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                R_ACCESS: begin
                    if (reg_readdatavalid) begin
                        axi_rdata  <= reg_readdata;
                        axi_rresp  <= RESP_OKAY;
                        axi_rvalid <= 1'b1;
                        state      <= R_RESP;
                    end
`ifdef REG_TIMEOUT_EN
                    else if (timed_out) begin
                        axi_rdata  <= 32'hDEAD_BEEF;
                        axi_rresp  <= RESP_SLVERR;
                        axi_rvalid <= 1'b1;
                        state      <= R_RESP;
                    end
`endif
                end
                R_RESP: begin
                    if (axi_rready) begin
                        axi_rvalid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_lite_reg_responder.sv
// Bench for axi_lite_reg_responder: directed scenarios plus randomized back-to-back traffic
// checked against a word-array model of the register space.
`timescale 1ns/1ps
module tb_axi_lite_reg_responder;
    localparam int AW = 12;
    localparam int TO = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic [AW-1:0] awaddr, araddr, reg_addr;
    logic          awvalid, awready, wvalid, wready, bvalid, bready;
    logic          arvalid, arready, rvalid, rready;
    logic [31:0]   wdata, rdata, reg_writedata, reg_readdata;
    logic [3:0]    wstrb, reg_beN;
    logic [1:0]    bresp, rresp;
    logic          reg_write, reg_read, reg_ack, reg_readdatavalid;

    axi_lite_reg_responder #(.AXI_ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
        .axi_clk(clk), .axi_reset_n(rst_n),
        .axi_awaddr(awaddr), .axi_awvalid(awvalid), .axi_awready(awready),
        .axi_wdata(wdata), .axi_wstrb(wstrb), .axi_wvalid(wvalid), .axi_wready(wready),
        .axi_bresp(bresp), .axi_bvalid(bvalid), .axi_bready(bready),
        .axi_araddr(araddr), .axi_arvalid(arvalid), .axi_arready(arready),
        .axi_rdata(rdata), .axi_rresp(rresp), .axi_rvalid(rvalid), .axi_rready(rready),
        .reg_addr(reg_addr), .reg_write(reg_write), .reg_read(reg_read),
        .reg_writedata(reg_writedata), .reg_beN(reg_beN), .reg_ack(reg_ack),
        .reg_readdata(reg_readdata), .reg_readdatavalid(reg_readdatavalid)
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] model [16];
    logic [31:0] rf [16];
    int ack_lat = 0, rd_lat = 0;
    bit rd_mute = 0, late_rv = 0;
    int wr_strobes = 0, rd_strobes = 0, both_strobes = 0;
    logic [AW-1:0] last_wr_addr = '0, last_rd_addr = '0;
    logic [31:0]   last_wr_data = '0;
    logic [3:0]    last_wr_ben = '0;

    // Register-file stand-in: stores writes, answers reads and acks after the programmed latencies.
    initial begin
        int wcd, rcd;
        logic [AW-1:0] raddr;
        wcd = -1; rcd = -1; raddr = '0;
        reg_ack = 1'b0; reg_readdatavalid = 1'b0; reg_readdata = '0;
        for (int i = 0; i < 16; i++) rf[i] = '0;
        forever begin
            @(posedge clk); #1;
            reg_ack = 1'b0; reg_readdatavalid = 1'b0;
            if (!rst_n) begin wcd = -1; rcd = -1; end
            if (reg_write && reg_read) both_strobes++;
            if (reg_write) begin
                wr_strobes++;
                last_wr_addr = reg_addr; last_wr_data = reg_writedata; last_wr_ben = reg_beN;
                for (int b = 0; b < 4; b++)
                    if (!reg_beN[b]) rf[reg_addr[5:2]][8*b +: 8] = reg_writedata[8*b +: 8];
                wcd = ack_lat;
            end
            if (reg_read) begin
                rd_strobes++; last_rd_addr = reg_addr; raddr = reg_addr;
                if (!rd_mute) rcd = rd_lat;
            end
            if (wcd == 0) begin reg_ack = 1'b1; wcd = -1; end
            else if (wcd > 0) wcd--;
            if (rcd == 0) begin
                reg_readdatavalid = 1'b1; reg_readdata = rf[raddr[5:2]]; rcd = -1;
            end else if (rcd > 0) rcd--;
            else if (late_rv) begin
                reg_readdatavalid = 1'b1; reg_readdata = 32'h1111_2222; late_rv = 0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, n_bad=%0d", n_bad);
        $fatal(1);
    end

    task automatic axi_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int aw_start, input int w_start, output bit ok);
        bit aw_done, w_done, aw_fire, w_fire;
        int cyc;
        aw_done = 0; w_done = 0; cyc = 0;
        while (!(aw_done && w_done) && cyc < 40) begin
            @(negedge clk);
            awaddr = a; wdata = d; wstrb = s;
            awvalid = !aw_done && (cyc >= aw_start);
            wvalid  = !w_done && (cyc >= w_start);
            #1;
            aw_fire = awvalid && awready;
            w_fire  = wvalid && wready;
            @(posedge clk);
            if (aw_fire) aw_done = 1;
            if (w_fire) w_done = 1;
            cyc++;
        end
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        ok = aw_done && w_done;
    endtask

    task automatic axi_read_addr(input logic [AW-1:0] a, output bit ok);
        bit fire;
        int cyc;
        fire = 0; cyc = 0;
        while (!fire && cyc < 40) begin
            @(negedge clk);
            araddr = a; arvalid = 1'b1;
            #1 fire = arready;
            @(posedge clk);
            cyc++;
        end
        @(negedge clk);
        arvalid = 1'b0;
        ok = fire;
    endtask

    task automatic wait_bvalid(input int limit, output int cyc);
        cyc = 0;
        while (bvalid !== 1'b1 && cyc < limit) begin @(negedge clk); cyc++; end
    endtask

    task automatic wait_rvalid(input int limit, output int cyc);
        cyc = 0;
        while (rvalid !== 1'b1 && cyc < limit) begin @(negedge clk); cyc++; end
    endtask

    task automatic b_accept();
        bready = 1'b1; @(negedge clk); bready = 1'b0;
    endtask

    task automatic r_accept();
        rready = 1'b1; @(negedge clk); rready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_cmp++; if ({awready, wready, arready, bvalid, rvalid, reg_write, reg_read} !== 7'b0)
            begin n_bad++; $display("FAIL reset_ctrl: got %b want 0000000", {awready, wready, arready, bvalid, rvalid, reg_write, reg_read}); end
        n_cmp++; if ({bresp, rresp, rdata, reg_addr, reg_writedata, reg_beN} !== '0)
            begin n_bad++; $display("FAIL reset_data: rdata=%h reg_addr=%h wd=%h beN=%b resp=%b%b want all 0", rdata, reg_addr, reg_writedata, reg_beN, bresp, rresp); end
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if ({awready, wready, arready} !== 3'b111)
            begin n_bad++; $display("FAIL reset_ready: got %b want 111", {awready, wready, arready}); end
    endtask

    task automatic test_write_same_cycle();
        int w0;
        ack_lat = 0; w0 = wr_strobes;
        awaddr = 12'h010; wdata = 32'h1234_5678; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        #1;
        n_cmp++; if ({awready, wready, arready} !== 3'b110)
            begin n_bad++; $display("FAIL t1_ready: got %b want 110", {awready, wready, arready}); end
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        n_cmp++; if ({reg_write, reg_beN, reg_addr, reg_writedata, bvalid} !== {1'b1, 4'h0, 12'h010, 32'h1234_5678, 1'b0})
            begin n_bad++; $display("FAIL t1_strobe: wr=%b beN=%b addr=%h data=%h bvalid=%b want 1 0000 010 12345678 0", reg_write, reg_beN, reg_addr, reg_writedata, bvalid); end
        @(negedge clk);
        n_cmp++; if ({reg_write, bvalid, bresp} !== 4'b0100)
            begin n_bad++; $display("FAIL t1_bvalid: wr=%b bvalid=%b bresp=%b want 0 1 00", reg_write, bvalid, bresp); end
        b_accept();
        n_cmp++; if ({bvalid, awready, wready} !== 3'b011 || wr_strobes - w0 != 1)
            begin n_bad++; $display("FAIL t1_done: bvalid=%b aw/wready=%b%b strobes=%0d want 0 11 1", bvalid, awready, wready, wr_strobes - w0); end
        model[4] = 32'h1234_5678;
    endtask

    task automatic test_w_before_aw();
        bit ok;
        int c, w0, held;
        ack_lat = 2; w0 = wr_strobes; held = 0;
        axi_write(12'h013, 32'hA5A5_0F0F, 4'hF, 3, 0, ok);
        wait_bvalid(20, c);
        n_cmp++; if (!ok || c != ack_lat + 1 || bresp !== 2'b00)
            begin n_bad++; $display("FAIL t2_bvalid: ok=%0d lat=%0d bresp=%b want 1 %0d 00", ok, c, bresp, ack_lat + 1); end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (bvalid === 1'b1 && bresp === 2'b00) held++;
        end
        n_cmp++; if (held != 5)
            begin n_bad++; $display("FAIL t2_hold: got %0d want 5", held); end
        b_accept();
        n_cmp++; if (bvalid !== 1'b0 || wr_strobes - w0 != 1 || last_wr_addr !== 12'h010 || last_wr_data !== 32'hA5A5_0F0F)
            begin n_bad++; $display("FAIL t2_access: bvalid=%b strobes=%0d addr=%h data=%h want 0 1 010 a5a50f0f", bvalid, wr_strobes - w0, last_wr_addr, last_wr_data); end
        model[4] = 32'hA5A5_0F0F;
    endtask

    task automatic test_read();
        bit ok;
        int c, r0, held;
        ack_lat = 0; rd_lat = 4; held = 0;
        axi_write(12'h020, 32'hCAFE_F00D, 4'hF, 0, 0, ok);
        wait_bvalid(20, c);
        b_accept();
        model[8] = 32'hCAFE_F00D;
        r0 = rd_strobes;
        axi_read_addr(12'h020, ok);
        n_cmp++; if (!ok || {reg_read, reg_addr} !== {1'b1, 12'h020})
            begin n_bad++; $display("FAIL t3_strobe: ok=%0d rd=%b addr=%h want 1 1 020", ok, reg_read, reg_addr); end
        wait_rvalid(20, c);
        n_cmp++; if (c != rd_lat + 1 || rdata !== model[8] || rresp !== 2'b00)
            begin n_bad++; $display("FAIL t3_rdata: lat=%0d rdata=%h rresp=%b want %0d %h 00", c, rdata, rresp, rd_lat + 1, model[8]); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (rvalid === 1'b1 && rdata === 32'hCAFE_F00D) held++;
        end
        n_cmp++; if (held != 3)
            begin n_bad++; $display("FAIL t3_hold: got %0d want 3", held); end
        r_accept();
        n_cmp++; if (rvalid !== 1'b0 || rd_strobes - r0 != 1)
            begin n_bad++; $display("FAIL t3_done: rvalid=%b strobes=%0d want 0 1", rvalid, rd_strobes - r0); end
    endtask

    task automatic test_arbitration();
        bit saw_b, fire, ok;
        int c, w0, r0;
        logic [31:0] d;
        ack_lat = 1; rd_lat = 0; w0 = wr_strobes; r0 = rd_strobes;
        d = $urandom; saw_b = 0; fire = 0;
        awaddr = 12'h028; wdata = d; wstrb = 4'hF; araddr = 12'h028;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1; bready = 1'b1;
        #1;
        n_cmp++; if ({awready, wready, arready} !== 3'b110)
            begin n_bad++; $display("FAIL t4_ready: got %b want 110", {awready, wready, arready}); end
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        for (int k = 0; k < 20 && !fire; k++) begin
            if (bvalid === 1'b1) saw_b = 1;
            #1 fire = arready;
            @(posedge clk);
            @(negedge clk);
        end
        arvalid = 1'b0; bready = 1'b0;
        model[10] = d;
        n_cmp++; if (!fire || !saw_b || wr_strobes - w0 != 1)
            begin n_bad++; $display("FAIL t4_order: ar_acc=%0d b_first=%0d wr_strobes=%0d want 1 1 1", fire, saw_b, wr_strobes - w0); end
        wait_rvalid(20, c);
        ok = (c == 1);
        n_cmp++; if (!ok || rdata !== model[10] || rd_strobes - r0 != 1 || last_rd_addr !== 12'h028)
            begin n_bad++; $display("FAIL t4_read: lat=%0d rdata=%h strobes=%0d addr=%h want 1 %h 1 028", c, rdata, rd_strobes - r0, last_rd_addr, model[10]); end
        r_accept();
    endtask

`ifdef REG_TIMEOUT_EN
    task automatic test_timeout();
        bit ok;
        int c, held;
        rd_mute = 1; held = 0;
        axi_read_addr(12'h030, ok);
        wait_rvalid(40, c);
        n_cmp++; if (!ok || c != TO || rresp !== 2'b10 || rdata !== 32'hDEAD_BEEF)
            begin n_bad++; $display("FAIL t5_timeout: lat=%0d rresp=%b rdata=%h want %0d 10 deadbeef", c, rresp, rdata, TO); end
        late_rv = 1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (rvalid === 1'b1 && rdata === 32'hDEAD_BEEF && rresp === 2'b10) held++;
        end
        n_cmp++; if (held != 3)
            begin n_bad++; $display("FAIL t5_late: got %0d want 3", held); end
        rd_mute = 0;
        r_accept();
    endtask
`endif

    task automatic test_reset_mid_read();
        bit ok;
        int c, quiet;
        logic [31:0] d;
        rd_mute = 1; quiet = 0; d = $urandom;
        axi_read_addr(12'h014, ok);
        n_cmp++; if (!ok || reg_read !== 1'b1)
            begin n_bad++; $display("FAIL t6_strobe: ok=%0d rd=%b want 1 1", ok, reg_read); end
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        n_cmp++; if ({rvalid, bvalid, reg_read, reg_write, awready, arready} !== 6'b0)
            begin n_bad++; $display("FAIL t6_reset: got %b want 000000", {rvalid, bvalid, reg_read, reg_write, awready, arready}); end
        rst_n = 1'b1; rd_mute = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (rvalid === 1'b0 && awready === 1'b1 && arready === 1'b1) quiet++;
        end
        n_cmp++; if (quiet != 3)
            begin n_bad++; $display("FAIL t6_idle: got %0d want 3", quiet); end
        ack_lat = 0;
        axi_write(12'h004, d, 4'hF, 0, 0, ok);
        wait_bvalid(20, c);
        n_cmp++; if (!ok || c != 1 || bresp !== 2'b00 || last_wr_addr !== 12'h004 || last_wr_data !== d)
            begin n_bad++; $display("FAIL t6_write: ok=%0d lat=%0d bresp=%b addr=%h data=%h want 1 1 00 004 %h", ok, c, bresp, last_wr_addr, last_wr_data, d); end
        b_accept();
        model[1] = d;
    endtask

    task automatic test_back_to_back();
        bit ok;
        int c, idx, w0, r0;
        logic [AW-1:0] a, aligned;
        logic [31:0] d;
        logic [3:0] s, ben_exp;
        for (int t = 0; t < 40; t++) begin
            idx = int'($urandom_range(0, 15));
            a = AW'(idx * 4 + int'($urandom_range(0, 3)));
            aligned = AW'(idx * 4);
            ack_lat = int'($urandom_range(0, 3));
            rd_lat = int'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 0) begin
                d = $urandom;
                s = ($urandom_range(0, 4) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
                ben_exp = ~s;
                w0 = wr_strobes;
                axi_write(a, d, s, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), ok);
                wait_bvalid(20, c);
                repeat ($urandom_range(0, 2)) @(negedge clk);
                n_cmp++; if (!ok || c != ack_lat + 1 || {bvalid, bresp} !== 3'b100)
                    begin n_bad++; $display("FAIL rnd_wr_resp[%0d]: ok=%0d lat=%0d bvalid=%b bresp=%b want 1 %0d 1 00", t, ok, c, bvalid, bresp, ack_lat + 1); end
                n_cmp++; if (wr_strobes - w0 != 1 || last_wr_addr !== aligned || last_wr_data !== d || last_wr_ben !== ben_exp)
                    begin n_bad++; $display("FAIL rnd_wr_bus[%0d]: n=%0d addr=%h data=%h beN=%b want 1 %h %h %b", t, wr_strobes - w0, last_wr_addr, last_wr_data, last_wr_ben, aligned, d, ben_exp); end
                b_accept();
                for (int b = 0; b < 4; b++) if (s[b]) model[idx][8*b +: 8] = d[8*b +: 8];
            end else begin
                r0 = rd_strobes;
                axi_read_addr(a, ok);
                wait_rvalid(20, c);
                repeat ($urandom_range(0, 2)) @(negedge clk);
                n_cmp++; if (!ok || c != rd_lat + 1 || rvalid !== 1'b1 || rdata !== model[idx] || rresp !== 2'b00)
                    begin n_bad++; $display("FAIL rnd_rd[%0d]: ok=%0d lat=%0d rvalid=%b rdata=%h rresp=%b want 1 %0d 1 %h 00", t, ok, c, rvalid, rdata, rresp, rd_lat + 1, model[idx]); end
                n_cmp++; if (rd_strobes - r0 != 1 || last_rd_addr !== aligned)
                    begin n_bad++; $display("FAIL rnd_rd_bus[%0d]: n=%0d addr=%h want 1 %h", t, rd_strobes - r0, last_rd_addr, aligned); end
                r_accept();
            end
        end
        n_cmp++; if (both_strobes != 0)
            begin n_bad++; $display("FAIL strobe_overlap: got %0d want 0", both_strobes); end
    endtask

    initial begin
        rst_n = 1'b0;
        awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; bready = 1'b0; rready = 1'b0;
        for (int i = 0; i < 16; i++) model[i] = '0;
        test_reset();
        test_write_same_cycle();
        test_w_before_aw();
        test_read();
        test_arbitration();
`ifdef REG_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid_read();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
